cla_seq_ctrl: RTL and testbench

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

---
 rtl/cla_seq_pkg.sv | 12 +
 rtl/cla_seq_ctrl_if.sv | 38 +++
 rtl/cla_slice4.sv | 27 ++
 rtl/cla_seq_ctrl.sv | 109 ++++++++++
 tb/tb_cla_seq_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared types and constants for the sequential CLA controller
package cla_seq_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;
endpackage

// File: rtl/cla_seq_ctrl_if.sv
// rtl/cla_seq_ctrl_if.sv - two-requester operand bus and result bus of the CLA controller
interface cla_seq_ctrl_if #(parameter int NIBBLES = 4);
  import cla_seq_pkg::*;
  localparam int W = NIBBLE_W * NIBBLES;

  logic          req0_valid;
  logic          req0_ready;
  logic [W-1:0]  req0_a;
  logic [W-1:0]  req0_b;
  logic          req0_sub;
  logic          req1_valid;
  logic          req1_ready;
  logic [W-1:0]  req1_a;
  logic [W-1:0]  req1_b;
  logic          req1_sub;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_sum;
  logic          res_cout;
  logic          res_ovf;
  req_id_t       res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_ovf, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_ovf, res_id
  );
endinterface

// File: rtl/cla_slice4.sv
// rtl/cla_slice4.sv - 4-bit carry-lookahead adder slice with group generate/propagate
module cla_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       gout,
  output logic       pout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pout = &p;
  assign cout = gout | (pout & cin);
  assign s    = p ^ c;
endmodule

// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - round-robin two-requester add/sub unit, one 4-bit CLA pass per cycle
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  cla_seq_ctrl_if.slave bus
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state, state_next;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_reg, b_reg, sum_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  req_id_t          id_reg, last_grant, grant;
  logic             ready0, ready1, accept;
  logic             cout_reg, ovf_reg;
  logic [NIBBLE_W-1:0] slice_s;
  logic             slice_cout, slice_g, slice_p;

  cla_slice4 u_slice (
    .a    (a_reg[idx]),
    .b    (b_reg[idx]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout),
    .gout (slice_g),
    .pout (slice_p)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = ~last_grant;
    ready0     = 1'b0;
    ready1     = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
          else if (bus.req1_valid)              grant = 1'b1;
          else                                  grant = 1'b0;
          ready0 = bus.req0_valid && (grant == 1'b0);
          ready1 = bus.req1_valid && (grant == 1'b1);
          accept = ready0 || ready1;
          if (accept) state_next = RUN;
        end
      end
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (bus.res_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg      <= grant ? bus.req1_a : bus.req0_a;
          if (grant) b_reg <= bus.req1_sub ? ~bus.req1_b : bus.req1_b;
          else       b_reg <= bus.req0_sub ? ~bus.req0_b : bus.req0_b;
          carry      <= grant ? bus.req1_sub : bus.req0_sub;
          id_reg     <= grant;
          last_grant <= grant;
          idx        <= '0;
        end
        RUN: begin
          sum_reg[idx] <= slice_s;
          carry        <= slice_cout;
          idx          <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            idx      <= '0;
            cout_reg <= slice_g | (slice_p & carry);
            ovf_reg  <= (a_reg[NIBBLES-1][NIBBLE_W-1] == b_reg[NIBBLES-1][NIBBLE_W-1]) &&
                        (slice_s[NIBBLE_W-1] != a_reg[NIBBLES-1][NIBBLE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = (state == DONE) && !rst;
  assign bus.res_sum    = sum_reg;
  assign bus.res_cout   = cout_reg;
  assign bus.res_ovf    = ovf_reg;
  assign bus.res_id     = id_reg;
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb/tb_cla_seq_ctrl.sv - directed self-checking bench for cla_seq_ctrl
module tb_cla_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  cla_seq_ctrl_if #(.NIBBLES(4)) bus();
  cla_seq_ctrl #(.NIBBLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 0;
    bus.res_ready  = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic consume();
    bus.res_ready = 1;
    @(posedge clk); #1;
  endtask

  // Issue one operation, scramble operands after accept, return at the first cycle res_valid is seen.
  task automatic run_op(input int who, input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat, output bit ok);
    int w;
    ok = 1; lat = 0; w = 0;
    @(negedge clk);
    if (who == 0) begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; end
    else          begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; end
    #1;
    while (!((who == 0) ? bus.req0_ready : bus.req1_ready)) begin
      if (w == 20) begin ok = 0; break; end
      @(negedge clk); #1; w++;
    end
    if (ok) begin
      @(posedge clk); #1;
      if (who == 0) begin bus.req0_valid = 0; bus.req0_a = 16'hDEAD; bus.req0_b = 16'hBEEF; bus.req0_sub = ~sub; end
      else          begin bus.req1_valid = 0; bus.req1_a = 16'hDEAD; bus.req1_b = 16'hBEEF; bus.req1_sub = ~sub; end
      while (!bus.res_valid) begin
        if (lat == 20) begin ok = 0; break; end
        @(posedge clk); #1; lat++;
      end
    end else begin
      bus.req0_valid = 0; bus.req1_valid = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; bus.req0_valid = 1; bus.req1_valid = 1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL rst_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready}); else passed++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.res_valid); else passed++;
    rst = 0; #1;
    checks++; if (bus.res_sum !== 16'h0000) $display("FAIL rst_sum: got %h expected 0000", bus.res_sum); else passed++;
    checks++; if ({bus.res_cout, bus.res_ovf, bus.res_id} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {bus.res_cout, bus.res_ovf, bus.res_id}); else passed++;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL rst_first_tie: got %b expected 10", {bus.req0_ready, bus.req1_ready}); else passed++;
    bus.req0_valid = 0; bus.req1_valid = 0;
  endtask

  task automatic test_basic_add();
    int lat; bit ok;
    run_op(0, 16'h1234, 16'h0FFF, 0, lat, ok);
    checks++; if (!ok) $display("FAIL add_done: got timeout expected result"); else passed++;
    checks++; if (lat !== 4) $display("FAIL add_latency: got %0d expected 4", lat); else passed++;
    checks++; if (bus.res_sum !== 16'h2233) $display("FAIL add_sum: got %h expected 2233", bus.res_sum); else passed++;
    checks++; if ({bus.res_cout, bus.res_ovf, bus.res_id} !== 3'b000) $display("FAIL add_flags: got %b expected 000", {bus.res_cout, bus.res_ovf, bus.res_id}); else passed++;
    consume();
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL add_release: got %b expected 0", bus.res_valid); else passed++;
  endtask

  task automatic test_carry_ovf();
    int lat; bit ok;
    run_op(0, 16'hFFFF, 16'h0001, 0, lat, ok);
    checks++; if ({ok, bus.res_sum, bus.res_cout, bus.res_ovf} !== {1'b1, 16'h0000, 1'b1, 1'b0}) $display("FAIL carry_wrap: got ok=%b sum=%h cout=%b ovf=%b expected ok=1 sum=0000 cout=1 ovf=0", ok, bus.res_sum, bus.res_cout, bus.res_ovf); else passed++;
    consume();
    run_op(0, 16'h7FFF, 16'h0001, 0, lat, ok);
    checks++; if ({ok, bus.res_sum, bus.res_cout, bus.res_ovf} !== {1'b1, 16'h8000, 1'b0, 1'b1}) $display("FAIL pos_ovf: got ok=%b sum=%h cout=%b ovf=%b expected ok=1 sum=8000 cout=0 ovf=1", ok, bus.res_sum, bus.res_cout, bus.res_ovf); else passed++;
    consume();
  endtask

  task automatic test_subtract();
    int lat; bit ok;
    run_op(1, 16'h0005, 16'h0007, 1, lat, ok);
    checks++; if ({ok, bus.res_sum, bus.res_cout, bus.res_ovf, bus.res_id} !== {1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1}) $display("FAIL sub_borrow: got ok=%b sum=%h cout=%b ovf=%b id=%b expected ok=1 sum=fffe cout=0 ovf=0 id=1", ok, bus.res_sum, bus.res_cout, bus.res_ovf, bus.res_id); else passed++;
    consume();
    run_op(0, 16'h8000, 16'h0001, 1, lat, ok);
    checks++; if ({ok, bus.res_sum, bus.res_cout, bus.res_ovf, bus.res_id} !== {1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0}) $display("FAIL sub_ovf: got ok=%b sum=%h cout=%b ovf=%b id=%b expected ok=1 sum=7fff cout=1 ovf=1 id=0", ok, bus.res_sum, bus.res_cout, bus.res_ovf, bus.res_id); else passed++;
    consume();
  endtask

  task automatic test_tie_arbitration();
    int grants[4];
    logic rid[4];
    logic [15:0] rsum[4];
    int ng = 0, nr = 0, both = 0;
    do_reset();
    bus.res_ready = 1;
    bus.req0_a = 16'h0010; bus.req0_b = 16'h0001; bus.req0_sub = 0;
    bus.req1_a = 16'h0020; bus.req1_b = 16'h0001; bus.req1_sub = 1;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      @(negedge clk); #1;
      if (bus.req0_ready && bus.req1_ready) both++;
      if ((bus.req0_ready || bus.req1_ready) && ng < 4) begin grants[ng] = bus.req1_ready ? 1 : 0; ng++; end
      if (bus.res_valid && nr < 4) begin rid[nr] = bus.res_id; rsum[nr] = bus.res_sum; nr++; end
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    checks++; if (both !== 0) $display("FAIL tie_both_ready: got %0d cycles expected 0", both); else passed++;
    checks++; if (nr !== 4) $display("FAIL tie_results: got %0d expected 4", nr); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (grants[i] !== (i % 2)) $display("FAIL tie_grant%0d: got %0d expected %0d", i, grants[i], i % 2); else passed++;
      checks++; if (rid[i] !== 1'((i % 2))) $display("FAIL tie_id%0d: got %b expected %0d", i, rid[i], i % 2); else passed++;
      checks++; if (rsum[i] !== ((i % 2) ? 16'h001F : 16'h0011)) $display("FAIL tie_sum%0d: got %h expected %h", i, rsum[i], (i % 2) ? 16'h001F : 16'h0011); else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat, w; bit ok;
    bus.res_ready = 0;
    run_op(0, 16'h0100, 16'h0023, 0, lat, ok);
    checks++; if (!ok) $display("FAIL bp_done: got timeout expected result"); else passed++;
    bus.req0_valid = 1; bus.req0_a = 16'h0002; bus.req0_b = 16'h0003; bus.req0_sub = 0;
    bus.req1_valid = 1; bus.req1_a = 16'h0010; bus.req1_b = 16'h0001; bus.req1_sub = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      checks++; if ({bus.res_valid, bus.res_sum, bus.res_cout, bus.res_ovf, bus.res_id, bus.req0_ready, bus.req1_ready} !== {1'b1, 16'h0123, 5'b00000}) $display("FAIL bp_hold%0d: got valid=%b sum=%h flags=%b rdy=%b%b expected valid=1 sum=0123 flags=000 rdy=00", c, bus.res_valid, bus.res_sum, {bus.res_cout, bus.res_ovf, bus.res_id}, bus.req0_ready, bus.req1_ready); else passed++;
    end
    bus.res_ready = 1;
    @(posedge clk); #1;
    checks++; if ({bus.res_valid, bus.req0_ready, bus.req1_ready} !== 3'b001) $display("FAIL bp_regrant: got valid=%b rdy=%b%b expected valid=0 rdy=01", bus.res_valid, bus.req0_ready, bus.req1_ready); else passed++;
    @(posedge clk); #1;
    bus.req1_valid = 0; bus.req1_a = 16'hDEAD;
    w = 0;
    while (!bus.res_valid && w < 20) begin @(posedge clk); #1; w++; end
    checks++; if ({bus.res_valid, bus.res_sum, bus.res_id} !== {1'b1, 16'h000F, 1'b1}) $display("FAIL bp_req1: got valid=%b sum=%h id=%b expected valid=1 sum=000f id=1", bus.res_valid, bus.res_sum, bus.res_id); else passed++;
    consume();
    run_op(0, 16'h0002, 16'h0003, 0, lat, ok);
    checks++; if ({ok, bus.res_sum, bus.res_id} !== {1'b1, 16'h0005, 1'b0}) $display("FAIL bp_req0_held: got ok=%b sum=%h id=%b expected ok=1 sum=0005 id=0", ok, bus.res_sum, bus.res_id); else passed++;
    consume();
  endtask

  task automatic test_reset_mid_op();
    int lat, pulses = 0; bit ok;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_sub = 0;
    @(posedge clk); #1;
    bus.req0_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (bus.res_valid) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL rstmid_no_result: got %0d valid cycles expected 0", pulses); else passed++;
    run_op(0, 16'h0001, 16'h0001, 0, lat, ok);
    checks++; if ({ok, bus.res_sum} !== {1'b1, 16'h0002}) $display("FAIL rstmid_next: got ok=%b sum=%h expected ok=1 sum=0002", ok, bus.res_sum); else passed++;
    checks++; if (lat !== 4) $display("FAIL rstmid_latency: got %0d expected 4", lat); else passed++;
    consume();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_add();
    test_carry_ovf();
    test_subtract();
    test_tie_arbitration();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
